wb_data_arbiter: RTL and testbench

//  Two-master Wishbone data-bus arbiter sharing one RAM/MMIO slave port.
//  M0 is the hart MEM-stage port (o_wb_stb/we/sel, o_data_addr, o_data, i_data).
//  M1 is a second requester (DMA / debug loader).

---
 rtl/wb_data_arbiter_if.sv | 26 ++
 rtl/wb_data_arbiter.sv | 96 +++++++++
 tb/tb_wb_data_arbiter.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_data_arbiter_if.sv
// Wishbone classic bus bundle: one instance per requesting master and one for the shared slave port.
interface wb_data_arbiter_if #(
    parameter int W = 32
);
    logic         cyc;
    logic         stb;
    logic         we;
    logic [3:0]   sel;
    logic [W-1:0] adr;
    logic [W-1:0] dat_w;
    logic [W-1:0] dat_r;
    logic         ack;
    logic         err;

    // Bus master drives the request and receives the response.
    modport master (
        output cyc, stb, we, sel, adr, dat_w,
        input  dat_r, ack, err
    );

    // Bus slave receives the request and drives the response.
    modport slave (
        input  cyc, stb, we, sel, adr, dat_w,
        output dat_r, ack, err
    );
endinterface

// File: rtl/wb_data_arbiter.sv
// Round-robin arbiter letting two Wishbone masters (hart MEM stage, DMA/debug) share one slave port.
// One transfer per grant, ended by ack, err, master abort or bus timeout.
module wb_data_arbiter #(
    parameter int W       = 32,
    parameter int TIMEOUT = 16,
    parameter int TW      = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    wb_data_arbiter_if.slave  m0_bus,
    wb_data_arbiter_if.slave  m1_bus,
    wb_data_arbiter_if.master s_bus
);
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    localparam logic [TW-1:0] TCNT_LAST = TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic [TW-1:0] TCNT_MAX  = '1;

    state_e          st_q;
    logic            gnt_q;
    logic            last_q;
    logic [TW-1:0]   tcnt_q;

    logic            busy;
    logic            g_stb;
    logic            g_we;
    logic [3:0]      g_sel;
    logic [W-1:0]    g_adr;
    logic [W-1:0]    g_dat_w;
    logic            resp_ok;
    logic            tout;
    logic            done;

    always_comb begin
        g_stb   = gnt_q ? m1_bus.stb   : m0_bus.stb;
        g_we    = gnt_q ? m1_bus.we    : m0_bus.we;
        g_sel   = gnt_q ? m1_bus.sel   : m0_bus.sel;
        g_adr   = gnt_q ? m1_bus.adr   : m0_bus.adr;
        g_dat_w = gnt_q ? m1_bus.dat_w : m0_bus.dat_w;
    end

    assign busy    = (st_q == ST_BUSY);
    // A master that dropped stb has aborted: it gets neither ack nor err, even from a timeout.
    assign resp_ok = busy & g_stb;
    assign tout    = (TIMEOUT != 0) && resp_ok && (tcnt_q == TCNT_LAST)
                     && !s_bus.ack && !s_bus.err;
    assign done    = s_bus.ack | s_bus.err | tout | ~g_stb;

    assign s_bus.cyc   = busy;
    assign s_bus.stb   = resp_ok;
    assign s_bus.we    = busy & g_we;
    assign s_bus.sel   = busy ? g_sel   : '0;
    assign s_bus.adr   = busy ? g_adr   : '0;
    assign s_bus.dat_w = busy ? g_dat_w : '0;

    assign m0_bus.ack   = resp_ok & ~gnt_q & s_bus.ack;
    assign m0_bus.err   = resp_ok & ~gnt_q & (s_bus.err | tout);
    assign m1_bus.ack   = resp_ok &  gnt_q & s_bus.ack;
    assign m1_bus.err   = resp_ok &  gnt_q & (s_bus.err | tout);

    // Read data is broadcast; it is only forced low while reset is held.
    assign m0_bus.dat_r = rst_n ? s_bus.dat_r : '0;
    assign m1_bus.dat_r = rst_n ? s_bus.dat_r : '0;

    // NOTE: non-blocking assignments so every register samples the pre-edge state, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= ST_IDLE;
            gnt_q  <= 1'b0;
            last_q <= 1'b1;
            tcnt_q <= '0;
        end else begin
            case (st_q)
                ST_IDLE: begin
                    if (m0_bus.stb || m1_bus.stb) begin
                        st_q   <= ST_BUSY;
                        tcnt_q <= '0;
                        gnt_q  <= (m0_bus.stb && m1_bus.stb) ? ~last_q : m1_bus.stb;
                    end
                end
                ST_BUSY: begin
                    if (done) begin
                        st_q   <= ST_IDLE;
                        last_q <= gnt_q;
                    end else if (tcnt_q != TCNT_MAX) begin
                        tcnt_q <= tcnt_q + 1'b1;
                    end
                end
                default: st_q <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_data_arbiter.sv
// Directed bench for wb_data_arbiter: grant order, datapath muxing, timeout, abort and reset behaviour.
module tb_wb_data_arbiter;
    localparam int W = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    wb_data_arbiter_if #(.W(W)) m0_if ();
    wb_data_arbiter_if #(.W(W)) m1_if ();
    wb_data_arbiter_if #(.W(W)) s_if ();

    wb_data_arbiter #(.W(W), .TIMEOUT(8), .TW(5)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .m0_bus (m0_if),
        .m1_bus (m1_if),
        .s_bus  (s_if)
    );

    always #5 clk = ~clk;

    assign m0_if.cyc = m0_if.stb;
    assign m1_if.cyc = m1_if.stb;

    // Control snapshot: {s_cyc, s_stb, m0_ack, m0_err, m1_ack, m1_err}
    function automatic logic [5:0] ctl();
        return {s_if.cyc, s_if.stb, m0_if.ack, m0_if.err, m1_if.ack, m1_if.err};
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic bus_idle();
        m0_if.stb = 1'b0; m0_if.we = 1'b0; m0_if.sel = 4'h0; m0_if.adr = '0; m0_if.dat_w = '0;
        m1_if.stb = 1'b0; m1_if.we = 1'b0; m1_if.sel = 4'h0; m1_if.adr = '0; m1_if.dat_w = '0;
        s_if.ack = 1'b0; s_if.err = 1'b0; s_if.dat_r = '0;
    endtask

    task automatic test_reset();
        logic [68:0] dp;
        bus_idle();
        rst_n = 1'b0;
        m0_if.stb = 1'b1; m0_if.we = 1'b1; m0_if.sel = 4'hF; m0_if.adr = 32'h55; m0_if.dat_w = 32'h66;
        m1_if.stb = 1'b1;
        s_if.ack = 1'b1; s_if.err = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        if (ctl() !== 6'b000000) begin
            n_bad++; $display("FAIL reset_ctl: got %b want %b", ctl(), 6'b000000);
        end
        n_cmp++;
        dp = {s_if.we, s_if.sel, s_if.adr, s_if.dat_w};
        if (dp !== '0) begin
            n_bad++; $display("FAIL reset_datapath: got %h want 0", dp);
        end
        n_cmp++;
        bus_idle();
        rst_n = 1'b1;
        tick();
        #1;
        if (ctl() !== 6'b000000) begin
            n_bad++; $display("FAIL reset_release_idle: got %b want %b", ctl(), 6'b000000);
        end
        n_cmp++;
    endtask

    task automatic test_m0_read();
        logic [5:0] exp;
        for (int c = 0; c < 5; c++) begin
            tick();
            m0_if.stb = (c < 4); m0_if.we = 1'b0; m0_if.sel = 4'hF; m0_if.adr = 32'h100;
            s_if.ack   = (c == 3);
            s_if.dat_r = (c == 3) ? 32'hDEADBEEF : 32'h0;
            #1;
            exp = (c == 0 || c == 4) ? 6'b000000 : ((c == 3) ? 6'b111000 : 6'b110000);
            if (ctl() !== exp) begin
                n_bad++; $display("FAIL m0_read_ctl c%0d: got %b want %b", c, ctl(), exp);
            end
            n_cmp++;
            if (c == 1 && {s_if.we, s_if.adr} !== {1'b0, 32'h100}) begin
                n_bad++; $display("FAIL m0_read_adr: got we=%b adr=%h want we=0 adr=100", s_if.we, s_if.adr);
            end
            if (c == 1) n_cmp++;
            if (c == 3 && {m0_if.dat_r, m1_if.dat_r} !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
                n_bad++; $display("FAIL m0_read_data: got m0=%h m1=%h want deadbeef", m0_if.dat_r, m1_if.dat_r);
            end
            if (c == 3) n_cmp++;
        end
    endtask

    task automatic test_tie();
        logic [5:0] exp_tab [7] = '{6'b000000, 6'b111000, 6'b000000, 6'b110010,
                                    6'b000000, 6'b111000, 6'b000000};
        tick();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 7; c++) begin
            tick();
            m0_if.stb = (c < 6); m0_if.adr = 32'hA0;
            m1_if.stb = (c < 6); m1_if.adr = 32'hB0;
            s_if.ack = 1'b0;
            #1;
            s_if.ack = s_if.stb;
            #1;
            if (ctl() !== exp_tab[c]) begin
                n_bad++; $display("FAIL tie_order c%0d: got %b want %b", c, ctl(), exp_tab[c]);
            end
            n_cmp++;
        end
        bus_idle();
    endtask

    task automatic test_m1_write();
        logic [5:0] exp_tab [7] = '{6'b000000, 6'b110000, 6'b110010, 6'b000000,
                                    6'b110000, 6'b111000, 6'b000000};
        logic [68:0] dp;
        for (int c = 0; c < 7; c++) begin
            tick();
            m0_if.stb = (c < 6); m0_if.we = 1'b0; m0_if.sel = 4'hF;    m0_if.adr = 32'h300; m0_if.dat_w = 32'hAAAA;
            m1_if.stb = (c < 3); m1_if.we = 1'b1; m1_if.sel = 4'b0011; m1_if.adr = 32'h20;  m1_if.dat_w = 32'h1234;
            s_if.ack = (c == 2 || c == 5);
            #1;
            if (ctl() !== exp_tab[c]) begin
                n_bad++; $display("FAIL m1_write_ctl c%0d: got %b want %b", c, ctl(), exp_tab[c]);
            end
            n_cmp++;
            dp = {s_if.we, s_if.sel, s_if.adr, s_if.dat_w};
            if (c == 1 && dp !== {1'b1, 4'b0011, 32'h20, 32'h1234}) begin
                n_bad++; $display("FAIL m1_write_bus: got %h want %h", dp, {1'b1, 4'b0011, 32'h20, 32'h1234});
            end
            if (c == 1) n_cmp++;
            if (c == 4 && dp !== {1'b0, 4'hF, 32'h300, 32'hAAAA}) begin
                n_bad++; $display("FAIL m0_after_m1_bus: got %h want %h", dp, {1'b0, 4'hF, 32'h300, 32'hAAAA});
            end
            if (c == 4) n_cmp++;
        end
        bus_idle();
    endtask

    task automatic test_abort();
        logic [5:0] exp_tab [4] = '{6'b000000, 6'b110000, 6'b100000, 6'b000000};
        for (int c = 0; c < 4; c++) begin
            tick();
            m1_if.stb = (c < 2); m1_if.adr = 32'hB0;
            #1;
            if (ctl() !== exp_tab[c]) begin
                n_bad++; $display("FAIL abort c%0d: got %b want %b", c, ctl(), exp_tab[c]);
            end
            n_cmp++;
        end
        bus_idle();
    endtask

    task automatic test_timeout();
        logic [5:0] exp;
        for (int c = 0; c < 13; c++) begin
            tick();
            m0_if.stb = (c < 9) || (c == 10) || (c == 11); m0_if.adr = 32'hA0;
            m1_if.stb = (c == 10) || (c == 11);            m1_if.adr = 32'hB0;
            s_if.ack  = (c == 11);
            #1;
            if (c >= 1 && c <= 7)  exp = 6'b110000;
            else if (c == 8)       exp = 6'b110100;
            else if (c == 11)      exp = 6'b110010;
            else                   exp = 6'b000000;
            if (ctl() !== exp) begin
                n_bad++; $display("FAIL timeout c%0d: got %b want %b", c, ctl(), exp);
            end
            n_cmp++;
        end
        bus_idle();
    endtask

    task automatic test_ack_timeout_tie();
        logic [5:0] exp;
        for (int c = 0; c < 13; c++) begin
            tick();
            m0_if.stb = (c < 9) || (c == 10) || (c == 11); m0_if.adr = 32'hA0;
            s_if.ack  = (c == 8) || (c == 11);
            s_if.err  = (c == 11);
            #1;
            if (c >= 1 && c <= 7)  exp = 6'b110000;
            else if (c == 8)       exp = 6'b111000;
            else if (c == 11)      exp = 6'b111100;
            else                   exp = 6'b000000;
            if (ctl() !== exp) begin
                n_bad++; $display("FAIL ack_tout_tie c%0d: got %b want %b", c, ctl(), exp);
            end
            n_cmp++;
        end
        bus_idle();
    endtask

    task automatic test_reset_mid_busy();
        tick();
        m1_if.stb = 1'b1; m1_if.adr = 32'hB0;
        tick();
        #1;
        if (ctl() !== 6'b110000) begin
            n_bad++; $display("FAIL rst_mid_pre: got %b want %b", ctl(), 6'b110000);
        end
        n_cmp++;
        #1;
        rst_n = 1'b0;
        m0_if.stb = 1'b1; m0_if.adr = 32'hA0;
        #1;
        if (ctl() !== 6'b000000) begin
            n_bad++; $display("FAIL rst_mid_drop: got %b want %b", ctl(), 6'b000000);
        end
        n_cmp++;
        tick();
        rst_n = 1'b1;
        #1;
        if (ctl() !== 6'b000000) begin
            n_bad++; $display("FAIL rst_mid_release: got %b want %b", ctl(), 6'b000000);
        end
        n_cmp++;
        tick();
        s_if.ack = 1'b1;
        #1;
        if (ctl() !== 6'b111000 || s_if.adr !== 32'hA0) begin
            n_bad++; $display("FAIL rst_mid_m0_first: got %b adr=%h want %b adr=a0", ctl(), s_if.adr, 6'b111000);
        end
        n_cmp++;
        tick();
        bus_idle();
        #1;
        if (ctl() !== 6'b000000) begin
            n_bad++; $display("FAIL rst_mid_final_idle: got %b want %b", ctl(), 6'b000000);
        end
        n_cmp++;
    endtask

    initial begin
        bus_idle();
        test_reset();
        test_m0_read();
        test_tie();
        test_m1_write();
        test_abort();
        test_timeout();
        test_ack_timeout_tie();
        test_reset_mid_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
